// File: rtl/uart_forward_fifo.sv
// Forwarding FIFO between a UART RX driver and a UART TX driver, with optional
// single-word substitution and a tx_start/tx_ready replay handshake.
module uart_forward_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            sys_clk,
    input  logic                            rst,
    input  logic                            fwd_en,
    input  logic                            rx_new_data,
    input  logic [DATA_WIDTH-1:0]           rx_data,
    input  logic                            tx_ready,
    output logic                            tx_start,
    output logic [DATA_WIDTH-1:0]           tx_data,
    input  logic                            replace_en,
    input  logic [DATA_WIDTH-1:0]           match_data,
    input  logic [DATA_WIDTH-1:0]           replace_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            overflow,
    input  logic                            overflow_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        BUSY_WAIT,
        DONE_WAIT
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] wr_word;
    logic                  push_req;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  lost;

    assign push_req = rx_new_data && fwd_en;
    assign full     = (fifo_count == DEPTH_C);
    assign wr_word  = (replace_en && (rx_data == match_data)) ? replace_data : rx_data;
    // A pop in the same cycle frees the slot, so a push while full still lands.
    assign push     = push_req && (!full || pop);
    assign lost     = push_req && full && !pop;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if ((fifo_count != '0) && fwd_en && tx_ready) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START:     state_d = BUSY_WAIT;
            BUSY_WAIT: if (!tx_ready) state_d = DONE_WAIT;
            DONE_WAIT: if (tx_ready) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
        end else begin
            state_q  <= state_d;
            tx_start <= pop;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr  <= rd_ptr + AW'(1);
                tx_data <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (lost) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // NOTE: storage has no reset; pointers and count define which entries are valid.
    always_ff @(posedge sys_clk) begin
        if (push) mem[wr_ptr] <= wr_word;
    end

endmodule

// File: tb/tb_uart_forward_fifo.sv
// Scoreboard bench for uart_forward_fifo: directed stimulus pushes expected TX
// words into a queue, a monitor pops and compares on every tx_start.
module tb_uart_forward_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          sys_clk = 1'b0;
    logic          rst = 1'b0;
    logic          fwd_en = 1'b1;
    logic          rx_new_data = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          tx_ready;
    logic          tx_start;
    logic [DW-1:0] tx_data;
    logic          replace_en = 1'b0;
    logic [DW-1:0] match_data = '0;
    logic [DW-1:0] replace_data = '0;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          overflow_clr = 1'b0;

    logic          model_ready = 1'b1;
    logic          hold = 1'b0;
    assign tx_ready = model_ready && !hold;

    int            tests = 0;
    int            fails = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] cur_exp = '0;
    logic          frame_active = 1'b0;
    logic          prev_start = 1'b0;

    uart_forward_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .fwd_en       (fwd_en),
        .rx_new_data  (rx_new_data),
        .rx_data      (rx_data),
        .tx_ready     (tx_ready),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .replace_en   (replace_en),
        .match_data   (match_data),
        .replace_data (replace_data),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // TX driver model: drops ready one edge after seeing tx_start, busy for 4 cycles.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (rst && tx_start) begin
                @(posedge sys_clk);
                #1 model_ready = 1'b0;
                repeat (4) @(posedge sys_clk);
                #1 model_ready = 1'b1;
            end
        end
    end

    always @(negedge sys_clk) begin
        if (!rst) begin
            frame_active = 1'b0;
            prev_start   = 1'b0;
        end else begin
            if (tx_start && prev_start) begin
                tests++;
                fails++;
                $display("FAIL tx_start_width: got 2+ cycles, expected 1");
            end
            if (tx_start) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_tx: got %0h, expected no transmission", tx_data);
                end else begin
                    cur_exp = exp_q.pop_front();
                    check("tx_data", 32'(tx_data), 32'(cur_exp));
                    frame_active = 1'b1;
                end
            end else if (frame_active && !tx_ready) begin
                check("tx_hold", 32'(tx_data), 32'(cur_exp));
            end
            prev_start = tx_start;
        end
    end

    task automatic push_word(input logic [DW-1:0] d);
        @(posedge sys_clk);
        #1 rx_new_data = 1'b1;
        rx_data = d;
        @(posedge sys_clk);
        #1 rx_new_data = 1'b0;
    endtask

    task automatic wait_low();
        int i;
        for (i = 0; i < 50; i++) begin
            @(posedge sys_clk);
            #2;
            if (!tx_ready) break;
        end
        check("wait_tx_busy", 32'(i < 50), 32'd1);
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 300; i++) begin
            @(posedge sys_clk);
            #2;
            if (exp_q.size() == 0 && fifo_count == '0) break;
        end
        repeat (10) @(posedge sys_clk);
        #2;
        check("drain_queue", 32'(exp_q.size()), 32'd0);
        check("drain_count", 32'(fifo_count), 32'd0);
    endtask

    initial begin
        #1;
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        #20 rst = 1'b1;

        // Single word with latency and count trace
        exp_q.push_back(8'hA5);
        push_word(8'hA5);
        check("single_count1", 32'(fifo_count), 32'd1);
        check("single_no_start", 32'(tx_start), 32'd0);
        @(posedge sys_clk);
        #1;
        check("single_start", 32'(tx_start), 32'd1);
        check("single_data", 32'(tx_data), 32'hA5);
        check("single_count0", 32'(fifo_count), 32'd0);
        drain();
        check("single_data_kept", 32'(tx_data), 32'hA5);

        // Burst against a slow TX
        for (int k = 1; k <= 5; k++) begin
            exp_q.push_back(DW'(k));
            push_word(DW'(k));
        end
        drain();
        check("burst_no_overflow", 32'(overflow), 32'd0);

        // Saturation, overflow and clear
        hold = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k < DEPTH) exp_q.push_back(8'h10 + DW'(k));
            push_word(8'h10 + DW'(k));
        end
        check("full_count", 32'(fifo_count), 32'd4);
        check("full_overflow", 32'(overflow), 32'd1);
        @(posedge sys_clk);
        #1 overflow_clr = 1'b1;
        @(posedge sys_clk);
        #1 overflow_clr = 1'b0;
        check("overflow_cleared", 32'(overflow), 32'd0);
        hold = 1'b0;
        drain();

        // Substitution
        replace_en   = 1'b1;
        match_data   = 8'h55;
        replace_data = 8'hAA;
        exp_q.push_back(8'hAA);
        push_word(8'h55);
        exp_q.push_back(8'h54);
        push_word(8'h54);
        drain();
        replace_en = 1'b0;

        // Drop while disabled
        fwd_en = 1'b0;
        push_word(8'h99);
        push_word(8'h98);
        repeat (5) @(posedge sys_clk);
        #1;
        check("drop_count", 32'(fifo_count), 32'd0);
        check("drop_overflow", 32'(overflow), 32'd0);

        // Disable mid-frame: in-flight word completes, the rest are held
        fwd_en = 1'b1;
        hold   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(8'h31 + DW'(k));
            push_word(8'h31 + DW'(k));
        end
        check("midframe_count3", 32'(fifo_count), 32'd3);
        hold = 1'b0;
        wait_low();
        fwd_en = 1'b0;
        repeat (20) @(posedge sys_clk);
        #1;
        check("midframe_held_count", 32'(fifo_count), 32'd2);
        check("midframe_held_queue", 32'(exp_q.size()), 32'd2);
        check("midframe_ready_back", 32'(tx_ready), 32'd1);
        fwd_en = 1'b1;
        drain();

        // Asynchronous reset during a transmission
        hold = 1'b1;
        for (int k = 0; k < 5; k++) push_word(8'h40 + DW'(k));
        check("pre_rst_overflow", 32'(overflow), 32'd1);
        exp_q.push_back(8'h40);
        hold = 1'b0;
        wait_low();
        #3 rst = 1'b0;
        #1;
        check("async_tx_start", 32'(tx_start), 32'd0);
        check("async_tx_data", 32'(tx_data), 32'd0);
        check("async_count", 32'(fifo_count), 32'd0);
        check("async_overflow", 32'(overflow), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge sys_clk);
        #1 rst = 1'b1;
        repeat (10) @(posedge sys_clk);
        #1;
        check("post_rst_count", 32'(fifo_count), 32'd0);
        check("post_rst_start", 32'(tx_start), 32'd0);
        exp_q.push_back(8'h66);
        push_word(8'h66);
        @(posedge sys_clk);
        #1;
        check("post_rst_idle_start", 32'(tx_start), 32'd1);
        check("post_rst_idle_data", 32'(tx_data), 32'h66);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_forward_fifo.md
Name: uart_forward_fifo

Overview:
- Sits between the RX side of one UART driver and the TX side of another UART driver in the man-in-the-middle path.
- Captures every frame the RX side flags with rx_new_data and queues it in a FIFO.
- Optionally substitutes one matching data word with a replacement word.
- Replays queued words to the TX driver using its tx_start/tx_ready handshake, holding tx_data stable for the whole frame.

Parameters:
DATA_WIDTH, 8, bits per UART frame; must equal the attached drivers' NUM_DATA_BITS.
FIFO_DEPTH, 16, FIFO entries; power of two, >= 2.

Ports:
sys_clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset (block in reset while 0)
fwd_en  input  1  1 = accept and forward frames; 0 = drop incoming frames, finish the frame in flight, then hold
rx_new_data  input  1  one-cycle pulse from the RX driver: rx_data valid this cycle
rx_data  input  DATA_WIDTH  received word
tx_ready  input  1  TX driver idle
tx_start  output  1  one-cycle pulse requesting transmission of tx_data
tx_data  output  DATA_WIDTH  word being transmitted; stable from tx_start until tx_ready returns to 1
replace_en  input  1  enable substitution
match_data  input  DATA_WIDTH  word to match
replace_data  input  DATA_WIDTH  substitute word
fifo_count  output  $clog2(FIFO_DEPTH+1)  current occupancy
overflow  output  1  sticky: a frame was lost because the FIFO was full
overflow_clr  input  1  clears overflow

Behaviour:
- Reset (rst=0, asynchronous): tx_start=0, tx_data=0, fifo_count=0, overflow=0. Read/write pointers go to 0 and the FSM goes to IDLE. Contents of FIFO storage are don't-care.
- Push:
  - Occurs on a cycle with rx_new_data=1 and fwd_en=1.
  - Stored word = (replace_en && rx_data==match_data) ? replace_data : rx_data.
  - The match/replace inputs are sampled on the push cycle only.
- Full:
  - A push while full and with no pop in the same cycle is discarded and sets overflow=1.
  - Push and pop in the same cycle while full: both take effect, no overflow, count unchanged.
- Empty: a pop never occurs while empty. Push and pop in the same cycle while empty is impossible, because a pop requires count>0.
- overflow:
  - Sets on the cycle after the lost push.
  - overflow_clr clears it on the next edge.
  - If clear and a new loss coincide, set wins.
- Pointers: log2(FIFO_DEPTH) bits, wrap modulo FIFO_DEPTH. fifo_count is updated each edge (+1 push only, -1 pop only, unchanged for both or neither).
- Drop: frames arriving while fwd_en=0 are discarded silently and do not affect overflow.
- FSM states:
  - IDLE: if fifo_count>0 and fwd_en=1 and tx_ready=1: pop the head word into tx_data, assert tx_start, go to START.
  - START: tx_start=0; go to BUSY_WAIT.
  - BUSY_WAIT: wait for tx_ready=0 (the driver drops it one edge after sampling tx_start); then go to DONE_WAIT.
  - DONE_WAIT: wait for tx_ready=1; then go to IDLE.
- tx_start is high exactly one cycle per word.
- Minimum latency from a push into an empty FIFO to tx_start high is 2 cycles: 1 edge to write storage/count, 1 edge in IDLE to load tx_data and set tx_start.
- Back-to-back transmissions: the next tx_start can occur no earlier than the cycle after tx_ready returns to 1.
- fwd_en falling mid-frame: the current frame completes, and the FSM stays in IDLE while fwd_en=0. Queued words are retained.
- tx_data holds its last value after a frame and changes only on a pop.

Test Plan:
- Reset with rst=0 mid-transmission -> tx_start=0, tx_data=0, fifo_count=0, overflow=0 immediately, asynchronously. After release the FSM is in IDLE.
- Single word 0xA5 pushed with the TX driver model idle -> tx_start pulses 2 cycles later with tx_data=0xA5. tx_data stays 0xA5 until tx_ready returns to 1, and fifo_count goes 1 then 0.
- Burst: push 0x01..0x05 on consecutive pulses while a slow TX model is busy -> five tx_start pulses in order 0x01..0x05, one per tx_ready low/high cycle. No overflow.
- FIFO_DEPTH=4, TX held busy, push 6 words -> fifo_count saturates at 4, overflow=1, and only the first 4 words are transmitted. overflow_clr=1 for one cycle -> overflow=0.
- replace_en=1, match_data=0x55, replace_data=0xAA; push 0x55, 0x54 -> transmitted 0xAA, 0x54.
- fwd_en=0: pulses of rx_new_data leave fifo_count at 0 and produce no tx_start. fwd_en dropped while a word is in flight -> that frame completes and the remaining queued words are held until fwd_en=1.
